// File: rtl/vector_mem_pkg.sv
// Types and default geometry shared by the banked vector memory and its read initiator.
package vector_mem_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 10;
    localparam int unsigned DEF_ADDR_WIDTH = 12;
    localparam int unsigned DEF_NUM_ELEM   = 16;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        DRAIN
    } rd_state_e;

    // Credits count up to FIFO_DEPTH inclusive.
    function automatic int unsigned credit_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/vector_mem_reader_if.sv
// Command, memory read port and vector output bundle of the vector memory reader.
interface vector_mem_reader_if
    import vector_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_ELEM    = DEF_NUM_ELEM,
    parameter int unsigned COUNT_WIDTH = 12
);
    logic                             cmd_valid;
    logic                             cmd_ready;
    logic [ADDR_WIDTH-1:0]            cmd_base_addr;
    logic [ADDR_WIDTH-1:0]            cmd_stride;
    logic [COUNT_WIDTH-1:0]           cmd_num_vec;
    logic [NUM_ELEM-1:0]              cmd_lane_mask;

    logic [NUM_ELEM-1:0]              mem_read_req;
    logic [ADDR_WIDTH*NUM_ELEM-1:0]   mem_read_addr;
    logic [DATA_WIDTH*NUM_ELEM-1:0]   mem_read_data;

    logic                             out_valid;
    logic                             out_ready;
    logic [DATA_WIDTH*NUM_ELEM-1:0]   out_data;
    logic                             out_last;

    logic                             busy;
    logic                             done;

    modport master (
        input  cmd_valid, cmd_base_addr, cmd_stride, cmd_num_vec, cmd_lane_mask,
        output cmd_ready,
        output mem_read_req, mem_read_addr,
        input  mem_read_data,
        output out_valid, out_data, out_last,
        input  out_ready,
        output busy, done
    );

    modport slave (
        output cmd_valid, cmd_base_addr, cmd_stride, cmd_num_vec, cmd_lane_mask,
        input  cmd_ready,
        input  mem_read_req, mem_read_addr,
        output mem_read_data,
        input  out_valid, out_data, out_last,
        output out_ready,
        input  busy, done
    );

endinterface

// File: rtl/vector_rd_fifo.sv
// Output vector buffer: synchronous FIFO with occupancy count and same-cycle push/pop.
module vector_rd_fifo #(
    parameter int unsigned WIDTH = 161,
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_pop;

    assign empty  = (count == '0);
    assign do_pop = pop && !empty;
    assign head   = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !do_pop) begin
                count <= count + 1'b1;
            end else if (!push && do_pop) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/vector_mem_reader.sv
// Strided vector read initiator: issues per-lane bank reads under output-buffer credit and streams vectors out.
module vector_mem_reader
    import vector_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int unsigned NUM_ELEM    = DEF_NUM_ELEM,
    parameter int unsigned COUNT_WIDTH = 12,
    parameter int unsigned RD_LATENCY  = 1,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input logic                 clk,
    input logic                 reset,
    vector_mem_reader_if.master bus
);
    localparam int unsigned VW = DATA_WIDTH * NUM_ELEM;
    localparam int unsigned CW = credit_width(FIFO_DEPTH);

    rd_state_e                      state;
    logic                           cmd_ready_q;
    logic                           busy_q;
    logic                           done_q;
    logic [NUM_ELEM-1:0]            req_q;
    logic [ADDR_WIDTH*NUM_ELEM-1:0] addr_q;
    logic [ADDR_WIDTH-1:0]          cur_addr;
    logic [ADDR_WIDTH-1:0]          stride;
    logic [COUNT_WIDTH-1:0]         remaining;
    logic [NUM_ELEM-1:0]            mask;
    logic                           iss_vld;
    logic                           iss_last;
    logic [RD_LATENCY-1:0]          ret_vld;
    logic [RD_LATENCY-1:0]          ret_last;
    logic [CW-1:0]                  in_flight;
    logic [CW-1:0]                  fifo_count;
    logic [CW:0]                    credits;
    logic                           fire;
    logic                           push;
    logic                           pop;
    logic                           fifo_empty;
    logic [VW-1:0]                  lane_keep;
    logic [VW:0]                    push_word;
    logic [VW:0]                    head;

    // Every vector holds a credit from issue until it leaves the FIFO, so a push always has room.
    assign credits = {1'b0, in_flight} + {1'b0, fifo_count};
    assign fire    = (state == ISSUE) && (credits < (CW + 1)'(FIFO_DEPTH));

    always_comb begin
        lane_keep = '0;
        for (int unsigned g = 0; g < NUM_ELEM; g++) begin
            lane_keep[g*DATA_WIDTH +: DATA_WIDTH] = {DATA_WIDTH{mask[g]}};
        end
    end

    assign push      = ret_vld[RD_LATENCY-1];
    assign push_word = {ret_last[RD_LATENCY-1], bus.mem_read_data & lane_keep};
    assign pop       = !fifo_empty && bus.out_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            req_q       <= '0;
            addr_q      <= '0;
            cur_addr    <= '0;
            stride      <= '0;
            remaining   <= '0;
            mask        <= '0;
            iss_vld     <= 1'b0;
            iss_last    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            req_q    <= '0;
            iss_vld  <= 1'b0;
            iss_last <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.cmd_valid && cmd_ready_q) begin
                        if (bus.cmd_num_vec != '0) begin
                            cur_addr    <= bus.cmd_base_addr;
                            stride      <= bus.cmd_stride;
                            remaining   <= bus.cmd_num_vec;
                            mask        <= bus.cmd_lane_mask;
                            busy_q      <= 1'b1;
                            cmd_ready_q <= 1'b0;
                            state       <= ISSUE;
                        end else begin
                            done_q <= 1'b1;
                        end
                    end
                end
                ISSUE: begin
                    if (fire) begin
                        req_q     <= mask;
                        addr_q    <= {NUM_ELEM{cur_addr}};
                        iss_vld   <= 1'b1;
                        iss_last  <= (remaining == COUNT_WIDTH'(1));
                        cur_addr  <= cur_addr + stride;
                        remaining <= remaining - 1'b1;
                        if (remaining == COUNT_WIDTH'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // The tagged last vector is the final FIFO entry, so its handoff empties the FIFO.
                    if (pop && head[VW] && (in_flight == '0)) begin
                        state       <= IDLE;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Return tracking starts at the issue register so it lines up with the RAM's data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ret_vld   <= '0;
            ret_last  <= '0;
            in_flight <= '0;
        end else begin
            ret_vld[0]  <= iss_vld;
            ret_last[0] <= iss_last;
            for (int unsigned i = 1; i < RD_LATENCY; i++) begin
                ret_vld[i]  <= ret_vld[i-1];
                ret_last[i] <= ret_last[i-1];
            end
            if (fire && !push) begin
                in_flight <= in_flight + 1'b1;
            end else if (!fire && push) begin
                in_flight <= in_flight - 1'b1;
            end
        end
    end

    vector_rd_fifo #(
        .WIDTH (VW + 1),
        .DEPTH (FIFO_DEPTH),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (pop),
        .head      (head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    assign bus.cmd_ready     = cmd_ready_q;
    assign bus.mem_read_req  = req_q;
    assign bus.mem_read_addr = addr_q;
    assign bus.out_valid     = !fifo_empty;
    assign bus.out_data      = head[VW-1:0];
    assign bus.out_last      = head[VW];
    assign bus.busy          = busy_q;
    assign bus.done          = done_q;

endmodule

// File: tb/tb_vector_mem_reader.sv
// Scoreboard bench for vector_mem_reader with a one-cycle-latency banked RAM model.
module tb_vector_mem_reader;

    localparam int unsigned DW   = 10;
    localparam int unsigned AW   = 12;
    localparam int unsigned NE   = 16;
    localparam int unsigned CNTW = 12;
    localparam int unsigned RL   = 1;
    localparam int unsigned FD   = 4;
    localparam int unsigned VW   = DW * NE;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    vector_mem_reader_if #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .NUM_ELEM    (NE),
        .COUNT_WIDTH (CNTW)
    ) bus ();

    vector_mem_reader #(
        .DATA_WIDTH  (DW),
        .ADDR_WIDTH  (AW),
        .NUM_ELEM    (NE),
        .COUNT_WIDTH (CNTW),
        .RD_LATENCY  (RL),
        .FIFO_DEPTH  (FD)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.master)
    );

    typedef struct packed {
        logic [NE-1:0] req;
        logic [AW-1:0] addr;
    } req_t;

    typedef struct packed {
        logic [VW-1:0] data;
        logic          last;
    } vec_t;

    req_t          exp_req[$];
    vec_t          exp_out[$];
    logic [AW-1:0] addr_log[$];
    int unsigned   cyc_log[$];

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned req_seen = 0;
    int unsigned out_seen = 0;
    int unsigned done_cnt = 0;
    int unsigned acc_cyc = 0;
    logic        lat_armed = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [DW-1:0] bank_word(input int unsigned g, input logic [AW-1:0] a);
        return DW'(32'(a) * 3 + g * 41 + 5);
    endfunction

    logic [VW-1:0] ram_q = '0;
    always @(posedge clk) begin
        for (int unsigned g = 0; g < NE; g++) begin
            ram_q[g*DW +: DW] <= bus.mem_read_req[g] ? bank_word(g, bus.mem_read_addr[g*AW +: AW])
                                                     : DW'(32'h2A5 + g);
        end
    end
    assign bus.mem_read_data = ram_q;

    task automatic check_u(input string name, input int unsigned act, input int unsigned exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_v(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string what);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got %s expected none", name, what);
    endtask

    // Memory-side and output-side monitors
    always @(negedge clk) begin : monitor
        req_t e;
        vec_t v;
        if (reset) begin
            if (bus.mem_read_req != '0) begin
                req_seen++;
                addr_log.push_back(bus.mem_read_addr[AW-1:0]);
                cyc_log.push_back(cyc);
                if (exp_req.size() == 0) begin
                    flag("unexpected_req", "mem_read_req active");
                end else begin
                    e = exp_req.pop_front();
                    check_u("req_mask", 32'(bus.mem_read_req), 32'(e.req));
                    check_v("req_addr", 256'(bus.mem_read_addr), 256'({NE{e.addr}}));
                end
            end
            if (bus.done) done_cnt++;
            if (bus.out_valid && lat_armed) begin
                check_u("first_out_latency", cyc - acc_cyc, 3);
                lat_armed = 1'b0;
            end
            if (bus.out_valid && bus.out_ready) begin
                out_seen++;
                if (exp_out.size() == 0) begin
                    flag("unexpected_out", "out handshake");
                end else begin
                    v = exp_out.pop_front();
                    check_v("out_data", 256'(bus.out_data), 256'(v.data));
                    check_u("out_last", 32'(bus.out_last), 32'(v.last));
                end
            end
        end
    end

    task automatic send_cmd(input logic [AW-1:0] base, input logic [AW-1:0] stride,
                            input int unsigned num, input logic [NE-1:0] mask);
        int unsigned t;
        req_t        r;
        vec_t        v;
        logic [AW-1:0] a;
        for (int unsigned i = 0; i < num; i++) begin
            a = AW'(32'(base) + i * 32'(stride));
            r.req  = mask;
            r.addr = a;
            exp_req.push_back(r);
            for (int unsigned g = 0; g < NE; g++) begin
                v.data[g*DW +: DW] = mask[g] ? bank_word(g, a) : '0;
            end
            v.last = (i == num - 1);
            exp_out.push_back(v);
        end
        bus.cmd_base_addr = base;
        bus.cmd_stride    = stride;
        bus.cmd_num_vec   = CNTW'(num);
        bus.cmd_lane_mask = mask;
        bus.cmd_valid     = 1'b1;
        t = 0;
        while (!bus.cmd_ready && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 100) flag("cmd_accept_timeout", "cmd_ready stuck low");
        @(posedge clk); #1;
        acc_cyc       = cyc;
        bus.cmd_valid = 1'b0;
    endtask

    task automatic wait_done(input int unsigned budget);
        int unsigned t;
        t = 0;
        while ((exp_out.size() != 0 || bus.busy || !bus.cmd_ready) && t < budget) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= budget) flag("drain_timeout", "still busy");
        repeat (2) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check_u({tag, "_cmd_ready"}, 32'(bus.cmd_ready), 1);
        check_u({tag, "_req"},       32'(bus.mem_read_req), 0);
        check_v({tag, "_addr"},      256'(bus.mem_read_addr), '0);
        check_u({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check_v({tag, "_out_data"},  256'(bus.out_data), '0);
        check_u({tag, "_out_last"},  32'(bus.out_last), 0);
        check_u({tag, "_busy"},      32'(bus.busy), 0);
        check_u({tag, "_done"},      32'(bus.done), 0);
    endtask

    logic [AW-1:0] basic_addr [4] = '{12'h010, 12'h011, 12'h012, 12'h013};
    logic [AW-1:0] wrap_addr  [3] = '{12'hFFE, 12'h001, 12'h004};

    initial begin : stimulus
        int unsigned d0;
        int unsigned r0;
        int unsigned o0;
        reset             = 1'b0;
        bus.cmd_valid     = 1'b0;
        bus.cmd_base_addr = '0;
        bus.cmd_stride    = '0;
        bus.cmd_num_vec   = '0;
        bus.cmd_lane_mask = '0;
        bus.out_ready     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // Basic sequential read
        addr_log.delete();
        cyc_log.delete();
        d0 = done_cnt;
        send_cmd(12'h010, 12'd1, 4, '1);
        lat_armed = 1'b1;
        check_u("busy_after_accept", 32'(bus.busy), 1);
        check_u("cmd_ready_after_accept", 32'(bus.cmd_ready), 0);
        wait_done(60);
        check_u("basic_req_count", addr_log.size(), 4);
        for (int unsigned i = 0; i < 4 && i < addr_log.size(); i++) begin
            check_v("basic_addr", 256'(addr_log[i]), 256'(basic_addr[i]));
            check_u("basic_req_cycle", cyc_log[i] - cyc_log[0], i);
        end
        check_u("basic_done_pulses", done_cnt - d0, 1);

        // Address wrap
        addr_log.delete();
        send_cmd(12'hFFE, 12'd3, 3, '1);
        wait_done(60);
        check_u("wrap_req_count", addr_log.size(), 3);
        for (int unsigned i = 0; i < 3 && i < addr_log.size(); i++) begin
            check_v("wrap_addr", 256'(addr_log[i]), 256'(wrap_addr[i]));
        end

        // Backpressure: issue must stop once all credits are held
        bus.out_ready = 1'b0;
        r0 = req_seen;
        o0 = out_seen;
        send_cmd(12'h100, 12'd5, 10, '1);
        repeat (20) @(posedge clk);
        #1;
        check_u("stall_req_count", req_seen - r0, FD);
        check_u("stall_req_idle", 32'(bus.mem_read_req), 0);
        check_u("stall_out_valid", 32'(bus.out_valid), 1);
        bus.out_ready = 1'b1;
        wait_done(100);
        check_u("bp_out_count", out_seen - o0, 10);

        // Partial lane mask
        send_cmd(12'h200, 12'h040, 2, 16'h00FF);
        wait_done(60);

        // Zero-length command
        r0 = req_seen;
        o0 = out_seen;
        send_cmd(12'h300, 12'd1, 0, '1);
        check_u("zero_done_now", 32'(bus.done), 1);
        check_u("zero_cmd_ready", 32'(bus.cmd_ready), 1);
        @(posedge clk); #1;
        check_u("zero_done_cleared", 32'(bus.done), 0);
        repeat (5) @(posedge clk);
        #1;
        check_u("zero_no_req", req_seen - r0, 0);
        check_u("zero_no_out", out_seen - o0, 0);
        check_u("zero_idle_ready", 32'(bus.cmd_ready), 1);

        // Reset in the middle of a command
        send_cmd(12'h300, 12'd1, 8, '1);
        repeat (2) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        check_reset_outputs("midrst");
        exp_req.delete();
        exp_out.delete();
        repeat (3) @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk); #1;
        o0 = out_seen;
        send_cmd(12'h050, 12'd2, 2, '1);
        wait_done(60);
        check_u("post_reset_out_count", out_seen - o0, 2);

        check_u("exp_req_left", exp_req.size(), 0);
        check_u("exp_out_left", exp_out.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end

endmodule

// File: doc/vector_mem_reader.md
Name: vector_mem_reader

Overview:
- Read initiator for the banked vector memory: accepts a strided vector-read command and drives per-lane read_req/read_addr into the NUM_ELEM banks.
- Captures bank read data after the fixed RAM latency and streams whole vectors out on a valid/ready interface.
- Sits between the instruction/DMA controller and the vector memory; it is the consumer side of the memory's read port.
- Credit-based issue guarantees no returned read data is ever dropped under output backpressure.

Parameters:
- DATA_WIDTH, 10: bits per lane element.
- ADDR_WIDTH, 12: bank address width.
- NUM_ELEM, 16: lanes/banks per vector.
- COUNT_WIDTH, 12: width of the vector-count field.
- RD_LATENCY, 1: cycles from read_req to valid read_data; legal range 1..4.
- FIFO_DEPTH, 4: output buffer depth in vectors; must be a power of 2 and >= RD_LATENCY+1.

Ports:
- clk  in  1  clock; all logic is rising-edge.
- reset  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  high only in IDLE.
- cmd_base_addr  in  ADDR_WIDTH  address of vector 0.
- cmd_stride  in  ADDR_WIDTH  address increment per vector.
- cmd_num_vec  in  COUNT_WIDTH  number of vectors to read.
- cmd_lane_mask  in  NUM_ELEM  1 = lane active.
- mem_read_req  out  NUM_ELEM  per-bank read strobe.
- mem_read_addr  out  ADDR_WIDTH*NUM_ELEM  per-bank address; lane g occupies [g*ADDR_WIDTH +: ADDR_WIDTH].
- mem_read_data  in  DATA_WIDTH*NUM_ELEM  per-bank data, valid RD_LATENCY cycles after the request.
- out_valid  out  1  vector available.
- out_ready  in  1  consumer accepts.
- out_data  out  DATA_WIDTH*NUM_ELEM  vector data; masked lanes read as 0.
- out_last  out  1  marks the final vector of the command.
- busy  out  1  high from command accept until the last vector is handed off.
- done  out  1  one-cycle pulse when the command completes.

Behaviour:
- Reset values (asserted low, async): FSM = IDLE; cmd_ready=1; mem_read_req=0; mem_read_addr=0; out_valid=0; out_data=0; out_last=0; busy=0; done=0; FIFO empty; all counters 0; latency shift registers cleared.
- Reset asserted mid-command aborts the command immediately. In-flight returns are discarded because the valid pipeline is cleared.
- FSM states:
  - IDLE: cmd_valid&cmd_ready with cmd_num_vec>0 latches base, stride, count and mask; next state ISSUE.
  - IDLE with cmd_num_vec==0: accepted, no reads issued, done pulses the next cycle, FSM stays IDLE.
  - ISSUE: goes to DRAIN in the cycle the last request issues.
  - DRAIN: returns to IDLE when in-flight==0, the FIFO is empty and the last vector has handshaked. done pulses in that same cycle the FSM re-enters IDLE.
- Issue rule: in ISSUE, a request fires in a cycle iff credits = in_flight + fifo_count < FIFO_DEPTH.
  - On fire: mem_read_req = latched mask, and every lane's address = cur_addr.
  - Otherwise: mem_read_req = 0.
  - mem_read_req and mem_read_addr are registered outputs.
- Address arithmetic: vector 0 uses cmd_base_addr; each subsequent vector adds cmd_stride. The sum is truncated to ADDR_WIDTH, i.e. wraps modulo 2^ADDR_WIDTH. Stride 0 is legal and repeats the same address.
- Return path:
  - A RD_LATENCY-deep valid/last shift register, aligned to the RAM's data return, pushes mem_read_data into the FIFO.
  - Masked lanes are forced to 0 before the push.
  - The last flag travels alongside the data.
  - in_flight increments on issue and decrements on push; a simultaneous issue and push leaves it unchanged.
- Output: FIFO head drives out_data/out_last and out_valid = !empty. Pop on out_valid&out_ready. Push and pop in the same cycle are legal when full; the credit rule means a push never finds the FIFO full without a concurrent pop.
- Throughput: one vector per cycle sustained when out_ready is held high. Command-to-first-out_valid latency = 1 (issue register) + RD_LATENCY + 1 (FIFO) cycles.
- A new command is not accepted until done; there is no overlap between commands.

Decomposition:
- Shared package vector_mem_pkg:
  - FSM state enum (IDLE, ISSUE, DRAIN).
  - Default DATA_WIDTH, ADDR_WIDTH and NUM_ELEM constants, shared with the vector memory.
  - Credit-width helper: clog2(FIFO_DEPTH+1).
- One sub-module, vector_rd_fifo: synchronous FIFO of width DATA_WIDTH*NUM_ELEM+1, depth FIFO_DEPTH, with count output, async active-low reset, and simultaneous push/pop.

Test Plan:
- Basic read: base=0x010, stride=1, num=4, mask=all, out_ready=1. Expect:
  - mem_read_addr steps 0x010..0x013 on four consecutive cycles.
  - Four out vectors equal the preloaded data.
  - out_last only on the 4th vector; done pulses once.
  - First out_valid at cycle 3 after accept (RD_LATENCY=1).
- Wrap: base=0xFFE, stride=3, num=3. Expect addresses 0xFFE, 0x001, 0x004.
- Backpressure: num=10 with out_ready low for 20 cycles. Expect:
  - Issue stalls after FIFO_DEPTH outstanding vectors.
  - mem_read_req stays 0 while stalled.
  - After release, all 10 vectors arrive in order with no drop or duplicate.
- Lane mask 0x00FF, num=2. Expect:
  - mem_read_req=0x00FF.
  - Lanes 8..15 of out_data are 0 even when the banks hold nonzero data.
- Zero count: cmd_num_vec=0. Expect no mem_read_req, no out_valid, done one cycle after accept, cmd_ready stays 1.
- Mid-command reset: assert reset low during ISSUE of a num=8 command. Expect:
  - All outputs go to their reset values immediately.
  - After release, a new num=2 command yields exactly 2 vectors with no stale data.
